deserializer_flex: RTL and testbench

DESERIALIZER_FLEX -- requirements
Module: deserializer_flex

---
 rtl/deserializer_flex_pkg.sv | 22 ++
 rtl/deserializer_flex_out_reg.sv | 49 ++++
 rtl/deserializer_flex.sv | 115 +++++++++++
 tb/tb_deserializer_flex.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_flex_pkg.sv
// Shared definitions for the flexible deserializer.
//   state_e     : accumulator state (ACCUM collects beats, HOLD waits for the output slot)
//   beat_offset : low bit position of beat <idx> inside the word for a given packing order
package deserializer_flex_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // MSB-first packs beat 0 into the top slice, LSB-first into the bottom slice.
  function automatic int unsigned beat_offset(input int unsigned idx,
                                              input logic        msb_first,
                                              input int unsigned data_width,
                                              input int unsigned in_width);
    if (msb_first) begin
      return data_width - (idx + 1) * in_width;
    end
    return idx * in_width;
  endfunction

endpackage

// File: rtl/deserializer_flex_out_reg.sv
// Output word register with its slot-free indication.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : capture data_i/len_i (caller only asserts it when slot_free_o = 1)
//   data_i, len_i  : word and valid-beat count to capture
//   rdy_i          : downstream ready
//   data_o, len_o  : registered word and length, stable while val_o & ~rdy_i
//   val_o          : word valid
//   slot_free_o    : register empty or being drained this cycle
module deserializer_flex_out_reg #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  rdy_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [LEN_W-1:0]      len_o,
  output logic                  val_o,
  output logic                  slot_free_o
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [LEN_W-1:0]      r_len;
  logic                  r_val;

  assign slot_free_o = ~r_val | rdy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= '0;
      r_len  <= '0;
      r_val  <= 1'b0;
    end else if (load_i) begin
      r_data <= data_i;
      r_len  <= len_i;
      r_val  <= 1'b1;
    end else if (rdy_i) begin
      r_val  <= 1'b0;
    end
  end

  assign data_o = r_data;
  assign len_o  = r_len;
  assign val_o  = r_val;

endmodule

// File: rtl/deserializer_flex.sv
// Flexible deserializer: packs IN_WIDTH-bit beats into DATA_WIDTH-bit words, MSB- or
// LSB-first, with flush of partial words and a one-word output register.
//   clk_i, rst_n_i    : clock, asynchronous active-low reset
//   data_i            : input beat
//   data_val_i        : beat valid
//   data_rdy_o        : beat ready (high in ACCUM)
//   msb_first_i       : packing order, sampled on beat 0 of each word
//   flush_i           : emit the current partial word
//   deser_data_o      : output word (unfilled positions are 0)
//   deser_len_o       : number of valid beats in the word
//   deser_data_val_o  : word valid
//   deser_data_rdy_i  : downstream ready
module deserializer_flex
  import deserializer_flex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_WIDTH   = 1,
  localparam int unsigned BEATS     = (IN_WIDTH == 0) ? 0 : DATA_WIDTH / IN_WIDTH,
  localparam int unsigned LEN_W     = $clog2(BEATS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  input  logic                  data_val_i,
  output logic                  data_rdy_o,
  input  logic                  msb_first_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] deser_data_o,
  output logic [LEN_W-1:0]      deser_len_o,
  output logic                  deser_data_val_o,
  input  logic                  deser_data_rdy_i
);

  if ((IN_WIDTH == 0) || (BEATS * IN_WIDTH != DATA_WIDTH) || (BEATS < 2)) begin : g_param_err
    $fatal(1, "deserializer_flex: DATA_WIDTH must be a multiple of IN_WIDTH with >= 2 beats");
  end

  state_e                r_state;
  logic [LEN_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_msb;

  logic                  w_accum;
  logic                  w_accept;
  logic                  w_order;
  logic                  w_complete;
  logic                  w_slot_free;
  logic                  w_load;
  logic [LEN_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_beat_placed;
  logic [DATA_WIDTH-1:0] w_acc_next;

  assign w_accum    = (r_state == ACCUM);
  assign data_rdy_o = w_accum;
  assign w_accept   = data_val_i & w_accum;

  // Beat 0 takes the live order input; later beats use the order latched with beat 0.
  assign w_order = (r_count == '0) ? msb_first_i : r_msb;

  assign w_beat_placed = DATA_WIDTH'(data_i)
                         << beat_offset(32'(r_count), w_order, DATA_WIDTH, IN_WIDTH);

  // In HOLD nothing is accepted, so these reduce to the held word and its length.
  assign w_acc_next   = w_accept ? (r_acc | w_beat_placed) : r_acc;
  assign w_count_next = r_count + LEN_W'(w_accept);

  assign w_complete = w_accum &
                      ((w_accept & (r_count == LEN_W'(BEATS - 1))) |
                       (flush_i & (w_count_next != '0)));

  // Load either a word completing now or the word parked in HOLD.
  assign w_load = w_slot_free & (~w_accum | w_complete);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ACCUM;
      r_count <= '0;
      r_acc   <= '0;
      r_msb   <= 1'b0;
    end else begin
      if (w_load) begin
        r_state <= ACCUM;
        r_count <= '0;
        r_acc   <= '0;
      end else if (w_complete) begin
        r_state <= HOLD;
        r_count <= w_count_next;
        r_acc   <= w_acc_next;
      end else if (w_accept) begin
        r_count <= w_count_next;
        r_acc   <= w_acc_next;
      end
      if (w_accept && (r_count == '0)) begin
        r_msb <= msb_first_i;
      end
    end
  end

  deserializer_flex_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_W     (LEN_W)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (w_load),
    .data_i     (w_acc_next),
    .len_i      (w_count_next),
    .rdy_i      (deser_data_rdy_i),
    .data_o     (deser_data_o),
    .len_o      (deser_len_o),
    .val_o      (deser_data_val_o),
    .slot_free_o(w_slot_free)
  );

endmodule

// File: tb/tb_deserializer_flex.sv
// Bench for deserializer_flex: unit 0 is DW=16/IW=1, unit 1 is DW=16/IW=4.
// A word-level model (queue of completed words, at most two outstanding) is checked
// against both units on every falling edge; directed tests pin it with literal words.
module tb_deserializer_flex;

  logic        clk;
  logic        rst_n;
  logic        s_val   [2];
  logic [3:0]  s_data  [2];
  logic        s_msb   [2];
  logic        s_flush [2];
  logic        s_rdy   [2];

  logic        d_rdy0, d_rdy1, d_val0, d_val1;
  logic [15:0] d_data0, d_data1;
  logic [4:0]  len0;
  logic [2:0]  len1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per unit
  logic [15:0] m_word [2][2];
  int          m_wlen [2][2];
  int          m_cnt  [2];
  logic [15:0] m_acc  [2];
  int          m_n    [2];
  logic        m_msb  [2];
  int          log0[$];
  int          log1[$];

  deserializer_flex #(.DATA_WIDTH(16), .IN_WIDTH(1)) u_dut0 (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .data_i          (s_data[0][0:0]),
    .data_val_i      (s_val[0]),
    .data_rdy_o      (d_rdy0),
    .msb_first_i     (s_msb[0]),
    .flush_i         (s_flush[0]),
    .deser_data_o    (d_data0),
    .deser_len_o     (len0),
    .deser_data_val_o(d_val0),
    .deser_data_rdy_i(s_rdy[0])
  );

  deserializer_flex #(.DATA_WIDTH(16), .IN_WIDTH(4)) u_dut1 (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .data_i          (s_data[1]),
    .data_val_i      (s_val[1]),
    .data_rdy_o      (d_rdy1),
    .msb_first_i     (s_msb[1]),
    .flush_i         (s_flush[1]),
    .deser_data_o    (d_data1),
    .deser_len_o     (len1),
    .deser_data_val_o(d_val1),
    .deser_data_rdy_i(s_rdy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int u, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s actual=0x%0h required=0x%0h at %0t", u, name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input logic val, input logic rdy,
                            input logic [15:0] data, input logic [31:0] len);
    int          iw;
    int          beats;
    logic [15:0] beat;
    logic [15:0] w;
    logic        slot_open;
    iw    = (u == 0) ? 1 : 4;
    beats = 16 / iw;
    if (!rst_n) begin
      chk(u, "rst_val", val, 0);
      chk(u, "rst_rdy", rdy, 1);
      chk(u, "rst_data", data, 0);
      chk(u, "rst_len", len, 0);
      m_cnt[u] = 0;
      m_n[u]   = 0;
      m_acc[u] = '0;
      return;
    end
    slot_open = (m_cnt[u] < 2);
    chk(u, "val", val, m_cnt[u] > 0);
    chk(u, "rdy", rdy, slot_open);
    if (m_cnt[u] > 0) begin
      chk(u, "data", data, m_word[u][0]);
      chk(u, "len", len, m_wlen[u][0]);
      if (s_rdy[u]) begin
        if (u == 0) log0.push_back((m_wlen[u][0] << 16) | int'(m_word[u][0]));
        else        log1.push_back((m_wlen[u][0] << 16) | int'(m_word[u][0]));
        m_word[u][0] = m_word[u][1];
        m_wlen[u][0] = m_wlen[u][1];
        m_cnt[u]--;
      end
    end
    if (slot_open) begin
      if (s_val[u]) begin
        beat = 16'(s_data[u]) & ((16'd1 << iw) - 16'd1);
        if (m_n[u] == 0) m_msb[u] = s_msb[u];
        if (m_msb[u]) m_acc[u] = (m_acc[u] << iw) | beat;
        else          m_acc[u] = m_acc[u] | (beat << (m_n[u] * iw));
        m_n[u]++;
      end
      if ((m_n[u] == beats) || (s_flush[u] && (m_n[u] > 0))) begin
        w = m_msb[u] ? (m_acc[u] << (16 - m_n[u] * iw)) : m_acc[u];
        m_word[u][m_cnt[u]] = w;
        m_wlen[u][m_cnt[u]] = m_n[u];
        m_cnt[u]++;
        m_n[u]   = 0;
        m_acc[u] = '0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, d_val0, d_rdy0, d_data0, 32'(len0));
    model_step(1, d_val1, d_rdy1, d_data1, 32'(len1));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Unit 0, MSB-first: send the top n bits of w, one per cycle.
  task automatic send_bits(input logic [15:0] w, input int n);
    logic [15:0] v;
    v = w;
    s_msb[0] = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_data[0] = {3'b000, v[15-i]};
      s_val[0]  = 1'b1;
      cycle();
    end
    s_val[0] = 1'b0;
  endtask

  function automatic int last_or(input int u, input int back);
    if (u == 0) return (log0.size() >= back) ? log0[log0.size() - back] : -1;
    return (log1.size() >= back) ? log1[log1.size() - back] : -1;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          base;
    int          idx;
    int          guard;
    logic        acc;
    logic [15:0] wsel;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      s_val[u] = 1'b0; s_data[u] = '0; s_msb[u] = 1'b1; s_flush[u] = 1'b0; s_rdy[u] = 1'b1;
    end
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // 0xA5C3 serial MSB-first: valid for exactly one cycle after the last bit
    base = log0.size();
    send_bits(16'hA5C3, 16);
    @(negedge clk);
    chk(0, "t1_val", d_val0, 1);
    chk(0, "t1_data", d_data0, 16'hA5C3);
    chk(0, "t1_len", len0, 16);
    cycle();
    @(negedge clk);
    chk(0, "t1_val_pulse", d_val0, 0);
    chk(0, "t1_log", last_or(0, 1), (16 << 16) | 16'hA5C3);
    chk(0, "t1_cnt", log0.size() - base, 1);
    cycle();

    // IW=4 LSB-first nibbles 1,2,3,4; order toggled after nibble 0 is ignored
    s_msb[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data[1] = 4'(i + 1);
      s_val[1]  = 1'b1;
      cycle();
      s_msb[1]  = 1'b1;
    end
    s_val[1] = 1'b0;
    repeat (3) cycle();
    chk(1, "t2_log", last_or(1, 1), (4 << 16) | 16'h4321);

    // Partial word 1,0,1,1,1 then flush; second flush with count 0 emits nothing
    base = log0.size();
    send_bits(16'hB800, 5);
    s_flush[0] = 1'b1;
    cycle();
    s_flush[0] = 1'b0;
    repeat (3) cycle();
    chk(0, "t3_log", last_or(0, 1), (5 << 16) | 16'hB800);
    base = log0.size();
    s_flush[0] = 1'b1;
    cycle();
    s_flush[0] = 1'b0;
    repeat (3) cycle();
    chk(0, "t3_noflush", log0.size() - base, 0);
    @(negedge clk);
    chk(0, "t3_noval", d_val0, 0);
    cycle();

    // Downstream stalled under a continuous stream: word 1 held, word 2 parked in HOLD
    base = log0.size();
    s_rdy[0] = 1'b0;
    s_msb[0] = 1'b1;
    idx = 0;
    guard = 0;
    while ((idx < 32) && (guard < 200)) begin
      wsel = (idx < 16) ? 16'h1357 : 16'h2468;
      s_data[0] = {3'b000, wsel[15 - (idx % 16)]};
      s_val[0]  = 1'b1;
      @(negedge clk);
      acc = d_rdy0;
      cycle();
      if (acc) idx++;
      guard++;
    end
    chk(0, "t4_beats", idx, 32);
    repeat (20) begin
      @(negedge clk);
      chk(0, "t4_rdy_low", d_rdy0, 0);
      chk(0, "t4_hold_data", d_data0, 16'h1357);
      cycle();
    end
    s_val[0] = 1'b0;
    s_rdy[0] = 1'b1;
    repeat (4) cycle();
    chk(0, "t4_cnt", log0.size() - base, 2);
    chk(0, "t4_word1", last_or(0, 2), (16 << 16) | 16'h1357);
    chk(0, "t4_word2", last_or(0, 1), (16 << 16) | 16'h2468);

    // Reset mid-word discards the partial word
    base = log0.size();
    send_bits(16'hFFFF, 7);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    send_bits(16'h1234, 16);
    repeat (3) cycle();
    chk(0, "t5_cnt", log0.size() - base, 1);
    chk(0, "t5_word", last_or(0, 1), (16 << 16) | 16'h1234);

    // Random traffic on both units
    base = log0.size() + log1.size();
    for (int c = 0; c < 10000; c++) begin
      for (int u = 0; u < 2; u++) begin
        s_val[u]   = ($urandom_range(0, 3) != 0);
        s_data[u]  = 4'($urandom);
        s_msb[u]   = 1'($urandom);
        s_flush[u] = ($urandom_range(0, 15) == 0);
        s_rdy[u]   = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    for (int u = 0; u < 2; u++) begin
      s_val[u] = 1'b0; s_flush[u] = 1'b0; s_rdy[u] = 1'b1;
    end
    repeat (5) cycle();
    chk(0, "rand_words", (log0.size() + log1.size() - base) > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
